// File: rtl/karatsuba_seq_mult.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_mult
// Sequential Karatsuba significand multiplier for the FPU mantissa datapath.
// Each SW-bit operand is split once into a high part (H bits) and a low part
// (L bits). The three partial products (high*high, low*low, sum*sum) are
// formed on a single shared (L+1)x(L+1) multiplier over three cycles, then
// recombined into the full 2*SW-bit product.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid_i    operand pair on Data_A_i/Data_B_i is valid
//   in_ready_o    block can accept an operand pair (IDLE only)
//   Data_A_i      unsigned operand A, SW bits
//   Data_B_i      unsigned operand B, SW bits
//   out_valid_o   sgf_result_o holds a new product (DONE only)
//   out_ready_i   consumer accepts the product
//   sgf_result_o  unsigned product A*B, 2*SW bits, held until the next result
//   busy_o        high in every state except IDLE
// ---------------------------------------------------------------------------
module karatsuba_seq_mult #(
  parameter int SW = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SW-1:0]     Data_A_i,
  input  logic [SW-1:0]     Data_B_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*SW-1:0]   sgf_result_o,
  output logic              busy_o
);

  localparam int H  = SW / 2;
  localparam int L  = SW - H;
  localparam int PW = 2 * L + 2;
  localparam int RW = 2 * SW;

  generate
    if (SW < 4 || SW > 64) begin : g_bad_sw
      $error("karatsuba_seq_mult: SW must be in 4..64");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_MID   = 3'd3,
    S_COMB  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SW-1:0]   r_a;
  logic [SW-1:0]   r_b;
  logic [PW-1:0]   r_ql;
  logic [PW-1:0]   r_qr;
  logic [PW-1:0]   r_qm;
  logic [RW-1:0]   r_result;

  logic [L:0]      w_ah;
  logic [L:0]      w_al;
  logic [L:0]      w_bh;
  logic [L:0]      w_bl;
  logic [L:0]      w_sa;
  logic [L:0]      w_sb;
  logic [L:0]      w_mul_a;
  logic [L:0]      w_mul_b;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_mid;
  logic [RW-1:0]   w_r;

  // Operand halves, zero-extended to the shared multiplier width; the sums keep their carry.
  assign w_ah = {{(L + 1 - H){1'b0}}, r_a[SW-1:L]};
  assign w_bh = {{(L + 1 - H){1'b0}}, r_b[SW-1:L]};
  assign w_al = {1'b0, r_a[L-1:0]};
  assign w_bl = {1'b0, r_b[L-1:0]};
  assign w_sa = w_ah + w_al;
  assign w_sb = w_bh + w_bl;

  // Shared multiplier operand select: which partial product is formed this cycle.
  always_comb begin
    w_mul_a = {(L + 1){1'b0}};
    w_mul_b = {(L + 1){1'b0}};
    case (r_state)
      S_LEFT: begin
        w_mul_a = w_ah;
        w_mul_b = w_bh;
      end
      S_RIGHT: begin
        w_mul_a = w_al;
        w_mul_b = w_bl;
      end
      S_MID: begin
        w_mul_a = w_sa;
        w_mul_b = w_sb;
      end
      default: begin
        w_mul_a = {(L + 1){1'b0}};
        w_mul_b = {(L + 1){1'b0}};
      end
    endcase
  end

  assign w_prod = {{(L + 1){1'b0}}, w_mul_a} * {{(L + 1){1'b0}}, w_mul_b};

  // QM - QL - QR equals ah*bl + al*bh, so it never goes negative.
  assign w_mid = r_qm - r_ql - r_qr;

  // Recombination. Carries out of bit 2*SW-1 cannot reach the kept bits, so
  // summing at the result width gives the same low bits as a wider sum.
  assign w_r = ({{(RW - PW){1'b0}}, r_ql} << (2 * L))
             + ({{(RW - PW){1'b0}}, w_mid} << L)
             +  {{(RW - PW){1'b0}}, r_qr};

  // Next-state logic: fixed LEFT..COMB walk, accept in IDLE, hold DONE under backpressure.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid_i) begin
          w_state_nxt = S_LEFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LEFT:  w_state_nxt = S_RIGHT;
      S_RIGHT: w_state_nxt = S_MID;
      S_MID:   w_state_nxt = S_COMB;
      S_COMB:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, operand capture, partial-product and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= {SW{1'b0}};
      r_b      <= {SW{1'b0}};
      r_ql     <= {PW{1'b0}};
      r_qr     <= {PW{1'b0}};
      r_qm     <= {PW{1'b0}};
      r_result <= {RW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_a <= Data_A_i;
            r_b <= Data_B_i;
          end
        end
        S_LEFT:  r_ql     <= w_prod;
        S_RIGHT: r_qr     <= w_prod;
        S_MID:   r_qm     <= w_prod;
        S_COMB:  r_result <= w_r;
        default: r_result <= r_result;
      endcase
    end
  end

  assign in_ready_o   = (r_state == S_IDLE);
  assign out_valid_o  = (r_state == S_DONE);
  assign busy_o       = (r_state != S_IDLE);
  assign sgf_result_o = r_result;

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Self-checking bench for karatsuba_seq_mult: an SW=54 instance with a
// scoreboard queue and random backpressure, plus an SW=7 instance for the
// odd-width split.
module tb_karatsuba_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;

  // SW = 54 instance
  logic          v54 = 1'b0;
  logic          rdy54;
  logic [53:0]   a54 = 54'd0;
  logic [53:0]   b54 = 54'd0;
  logic          ov54;
  logic          ordy54 = 1'b1;
  logic [107:0]  res54;
  logic          busy54;

  // SW = 7 instance
  logic          v7 = 1'b0;
  logic          rdy7;
  logic [6:0]    a7 = 7'd0;
  logic [6:0]    b7 = 7'd0;
  logic          ov7;
  logic          ordy7 = 1'b1;
  logic [13:0]   res7;
  logic          busy7;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [107:0]  q54[$];
  logic [13:0]   q7[$];
  logic          rdy_mode  = 1'b0;
  logic          rdy_force = 1'b1;

  karatsuba_seq_mult #(.SW(54)) u_dut54 (
    .clk(clk), .rst(rst), .in_valid_i(v54), .in_ready_o(rdy54),
    .Data_A_i(a54), .Data_B_i(b54), .out_valid_o(ov54), .out_ready_i(ordy54),
    .sgf_result_o(res54), .busy_o(busy54)
  );

  karatsuba_seq_mult #(.SW(7)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid_i(v7), .in_ready_o(rdy7),
    .Data_A_i(a7), .Data_B_i(b7), .out_valid_o(ov7), .out_ready_i(ordy7),
    .sgf_result_o(res7), .busy_o(busy7)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [107:0] mul54(input logic [53:0] a, input logic [53:0] b);
    logic [107:0] xa;
    logic [107:0] xb;
    xa = {54'd0, a};
    xb = {54'd0, b};
    return xa * xb;
  endfunction

  function automatic logic [53:0] rand54();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[53:0];
  endfunction

  // Consumer ready for the SW=54 instance: forced or random, changed just after the edge.
  always @(posedge clk) begin
    #1;
    if (rdy_mode) ordy54 = 1'($urandom_range(0, 1));
    else          ordy54 = rdy_force;
  end

  // Scoreboard: compare each handed-over product with the oldest expected value.
  always @(negedge clk) begin
    if (!rst && ov54 && ordy54) begin
      if (q54.size() == 0) begin
        check_eq("unexpected_out54", 128'(1), 128'(0));
      end else begin
        check_eq("prod54", 128'(res54), 128'(q54.pop_front()));
      end
    end
  end

  task automatic send54(input logic [53:0] a, input logic [53:0] b);
    int n;
    n = 0;
    @(negedge clk);
    a54 = a; b54 = b; v54 = 1'b1;
    while (!rdy54 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("accept_timeout54", 128'(0), 128'(1));
    else          q54.push_back(mul54(a, b));
    @(negedge clk);
    // Scramble inputs after the accept edge; the running operation must not see them.
    v54 = 1'b0; a54 = rand54(); b54 = rand54();
  endtask

  task automatic drain54();
    int n;
    n = 0;
    while ((q54.size() != 0 || !rdy54) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain54", 128'(q54.size()), 128'(0));
  endtask

  task automatic run7(input logic [6:0] a, input logic [6:0] b);
    int n;
    logic [13:0] xa;
    logic [13:0] xb;
    n = 0;
    @(negedge clk);
    a7 = a; b7 = b; v7 = 1'b1;
    while (!rdy7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    xa = {7'd0, a};
    xb = {7'd0, b};
    q7.push_back(xa * xb);
    @(negedge clk);
    v7 = 1'b0; a7 = 7'($urandom); b7 = 7'($urandom);
    n = 0;
    while (!ov7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("out_timeout7", 128'(0), 128'(1));
    else         check_eq("prod7", 128'(res7), 128'(q7.pop_front()));
  endtask

  initial begin
    int lat;
    int n;
    int seen;
    logic [53:0]  ones;
    logic [53:0]  pat;
    logic [107:0] hold;

    ones = {54{1'b1}};
    pat  = 54'h2AAAAAAAAAAAAA;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready",  128'(rdy54),  128'(1));
    check_eq("rst_valid",  128'(ov54),   128'(0));
    check_eq("rst_busy",   128'(busy54), 128'(0));
    check_eq("rst_result", 128'(res54),  128'(0));

    // T1: all-ones operands and the accept-to-valid latency.
    send54(ones, ones);
    check_eq("busy_running", 128'(busy54), 128'(1));
    check_eq("ready_running", 128'(rdy54), 128'(0));
    lat = 0;
    while (!ov54 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 128'(lat), 128'(4));
    drain54();
    check_eq("t1_const", 128'(res54), 128'(108'hFFFFFFFFFFFFF80000000000001));

    // T2: odd split on the SW=7 instance.
    run7(7'h7F, 7'h7F);
    check_eq("t2_const_a", 128'(res7), 128'(14'h3F01));
    run7(7'h55, 7'h2A);
    check_eq("t2_const_b", 128'(res7), 128'(14'h0DF2));

    // T3: zero and one operands.
    send54(54'd0, pat);
    drain54();
    check_eq("t3_zero", 128'(res54), 128'(0));
    send54(54'd1, pat);
    drain54();
    check_eq("t3_one", 128'(res54), 128'(pat));

    // T4: hold DONE for 10 cycles while the input side is wiggled.
    rdy_force = 1'b0;
    @(negedge clk);
    send54(54'h3456789ABCDEF, 54'h1FEDCBA987654);
    hold = mul54(54'h3456789ABCDEF, 54'h1FEDCBA987654);
    n = 0;
    while (!ov54 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v54 = 1'($urandom_range(0, 1)); a54 = rand54(); b54 = rand54();
      check_eq("bp_result", 128'(res54), 128'(hold));
      check_eq("bp_ready",  128'(rdy54), 128'(0));
      check_eq("bp_valid",  128'(ov54),  128'(1));
    end
    v54 = 1'b0;
    rdy_force = 1'b1;
    n = 0;
    while (!rdy54 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_release_cycles", 128'(n), 128'(2));
    check_eq("bp_valid_dropped", 128'(ov54), 128'(0));
    check_eq("bp_result_held", 128'(res54), 128'(hold));
    send54(54'd12345, 54'd67890);
    drain54();

    // T5: reset pulse while in MID.
    send54(rand54(), rand54());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q54.delete();
    check_eq("midrst_valid",  128'(ov54),   128'(0));
    check_eq("midrst_ready",  128'(rdy54),  128'(1));
    check_eq("midrst_busy",   128'(busy54), 128'(0));
    check_eq("midrst_result", 128'(res54),  128'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov54) seen++;
    end
    check_eq("midrst_no_pulse", 128'(seen), 128'(0));
    send54(54'd3, 54'd5);
    drain54();
    check_eq("midrst_3x5", 128'(res54), 128'(15));

    // T6: random operands with random gaps and random backpressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [53:0] ra;
      logic [53:0] rb;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 5))
        0:       ra = 54'd0;
        1:       ra = ones;
        default: ra = rand54();
      endcase
      case ($urandom_range(0, 5))
        0:       rb = ones;
        1:       rb = 54'd1;
        default: rb = rand54();
      endcase
      send54(ra, rb);
    end
    rdy_mode = 1'b0;
    drain54();
    for (int i = 0; i < 150; i++) begin
      run7(7'($urandom), 7'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
